// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_pkg : shared types and constants for pipeline stage registers
// rev 1.0
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_e;

  // IF/ID payload is {stop, inst}; an all-zero word is the NOP bubble.
  localparam int unsigned IFID_DATA_W = 33;
  localparam logic [IFID_DATA_W-1:0] IFID_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_skid_reg : valid/ready pipeline stage with optional 2-entry skid buffer
// rev 1.0
// ---------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W    = 32,
  parameter bit                 SKID      = 1'b1,
  parameter logic [DATA_W-1:0]  FLUSH_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              m_vld, s_vld;
  logic              in_fire, out_fire;

  assign m_vld    = (state_q != PS_EMPTY);
  assign s_vld    = (state_q == PS_FULL);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= PS_EMPTY;
      m_data_q <= FLUSH_VAL;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
    end
  end

  // Next state; without a skid register ONE can never overflow into FULL
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = PS_EMPTY;
    end else begin
      case (state_q)
        PS_EMPTY: if (in_fire) state_d = PS_ONE;
        PS_ONE: begin
          if (in_fire && !out_fire)      state_d = SKID ? PS_FULL : PS_ONE;
          else if (!in_fire && out_fire) state_d = PS_EMPTY;
        end
        PS_FULL:  if (out_fire) state_d = PS_ONE;
        default:  state_d = PS_EMPTY;
      endcase
    end
  end

  always_comb begin
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush) begin
      m_data_d = FLUSH_VAL;
      s_data_d = FLUSH_VAL;
    end else begin
      case (state_q)
        PS_EMPTY: if (in_fire) m_data_d = in_data;
        PS_ONE: begin
          if (in_fire && out_fire) m_data_d = in_data;
          else if (in_fire)        s_data_d = in_data;
        end
        PS_FULL:  if (out_fire) m_data_d = s_data_q;
        default:  m_data_d = m_data_q;
      endcase
    end
  end

  generate
    if (SKID) begin : g_skid
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) s_data_q <= FLUSH_VAL;
        else       s_data_q <= s_data_d;
      end
    end else begin : g_noskid
      assign s_data_q = FLUSH_VAL;
    end
  endgenerate

  // Outputs; the skid variant keeps in_ready free of any out_ready path
  always_comb begin
    out_valid = m_vld;
    out_data  = m_data_q;
    count     = {1'b0, m_vld} + {1'b0, s_vld};
    in_ready  = SKID ? ~s_vld : (~m_vld | out_ready);
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with valid/ready handshake, an optional two-entry skid buffer, and synchronous flush. It is the successor to the fixed 32-bit IF/ID latch and is instantiated between any two pipeline stages (IF/ID, ID/dispatch). Backpressure and branch or exception flushes are handled locally, so no stage needs a global stall wire. Payload is opaque: callers concatenate instruction, PC, stop flag and other fields into `in_data`.

## Interface
- `DATA_W`, 32: payload width in bits (≥1).
- `SKID`, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational ready pass-through.
- `FLUSH_VAL`, `{DATA_W{1'b0}}`: value loaded into data registers on reset and on flush (e.g. NOP encoding).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `flush`  in  1  synchronous kill of all held entries; highest priority.
- `in_valid`  in  1  upstream presents `in_data`.
- `in_ready`  out  1  stage can accept; transfer when `in_valid & in_ready`.
- `in_data`  in  `DATA_W`  upstream payload.
- `out_valid`  out  1  `out_data` holds a live entry.
- `out_ready`  in  1  downstream accepts; transfer when `out_valid & out_ready`.
- `out_data`  out  `DATA_W`  payload, driven directly from the main register.
- `count`  out  2  occupancy: 0, 1 or 2.

## Operation
- Storage: main register (M, drives `out_data`) and skid register (S, only when `SKID=1`). Flags: `m_vld`, `s_vld`.
- States (SKID=1): EMPTY (`m_vld=0`), ONE (`m_vld=1, s_vld=0`), FULL (both set).
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- EMPTY: `in_fire` → M←in_data, ONE.
- ONE: `in_fire & out_fire` → M←in_data, stays ONE. `in_fire & ~out_fire` → S←in_data, FULL. `out_fire` only → EMPTY.
- FULL: `in_ready=0`. `out_fire` → M←S, ONE.
- SKID=1: `in_ready = ~s_vld`, a pure register output with no combinational path from `out_ready`.
- SKID=0: no S. `in_ready = ~m_vld | out_ready` (combinational). FULL is unreachable and `count` ≤ 1.
- `out_valid = m_vld`; `count = m_vld + s_vld`.
- Flush: next state EMPTY. M and S ← FLUSH_VAL. Any `in_fire` in the same cycle is discarded. `out_fire` in the flush cycle still counts as delivered, because downstream already sampled the entry.
- Ordering: strict FIFO. No entry is duplicated or dropped except on flush.

## Timing
- Reset (async assert, synchronous-safe release): `out_valid=0`, `out_data=FLUSH_VAL`, `count=0`. `in_ready=1` (SKID=1), or 1 via `~m_vld` (SKID=0).
- Latency: an input accepted at edge N appears on `out_data` with `out_valid=1` after edge N. Entries passing through S see 2+ cycles.
- Throughput: 1 transfer/cycle sustained while `out_ready=1`.
- `in_ready` deasserts the cycle after S fills, and reasserts the cycle after FULL drains.
- While `out_valid=1 & out_ready=0`, `out_data` must remain stable.
- Reset asserted mid-transfer clears state immediately; partially accepted data is lost by design.

## Structure
- Shared package `pipe_pkg`: state enum `PS_EMPTY=2'd0`, `PS_ONE=2'd1`, `PS_FULL=2'd2`, plus the default NOP constant for the IF/ID instance.
- Single module, no sub-modules. The SKID=0 and SKID=1 datapaths are selected by a generate branch.
- Existing IF/ID use: `DATA_W=33` ({stop, inst}), `FLUSH_VAL=0`.

## Test plan
- Reset: hold `rstn=0` with random inputs → `out_valid=0`, `out_data=FLUSH_VAL`, `count=0`, `in_ready=1`. Release and send 0xDEADBEEF → it appears on the next cycle with `out_valid=1`.
- Streaming: `out_ready=1`, send 0x1,0x2,0x3 back-to-back → outputs on consecutive cycles, `count` stays 1, `in_ready` never drops.
- Backpressure (SKID=1): `out_ready=0`, send 0xA then 0xB → `count=2`, `in_ready=0`, `out_data=0xA` stable. Raise `out_ready` → 0xA, then 0xB, with no loss; `in_ready` returns to 1.
- Flush while FULL with `in_valid=1` (0xC) → next cycle `count=0`, `out_valid=0`, `out_data=FLUSH_VAL`, and 0xC never appears.
- Simultaneous in/out in ONE: hold 0x5, present 0x6 with `out_ready=1` → 0x5 consumed, `out_data=0x6`, `count=1`.
- SKID=0: `out_ready=0` with M full → `in_ready=0` in the same cycle. Toggle `out_ready=1` → `in_ready=1` combinationally, and a 1-entry pass-through works.
